// File: rtl/alu_pipe_if.sv
// Handshake bundle for the pipelined ALU: valid/ready request side carrying
// opcode, operands and tag, and valid/ready response side carrying result and flags.
interface alu_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_op;
    logic [XLEN-1:0]  in_a;
    logic [XLEN-1:0]  in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  result;
    logic             zero;
    logic             overflow;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, alu_op, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, result, zero, overflow, out_tag
    );

    modport slave (
        input  in_valid, alu_op, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, result, zero, overflow, out_tag
    );
endinterface

// File: rtl/alu_pipe.sv
// Pipelined RV32I-class integer ALU: results are computed combinationally ahead of stage 1,
// then travel through STAGES elastic registers with bubble-collapsing valid/ready flow control.
module alu_pipe #(
    parameter int XLEN   = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_pipe_if.slave bus
);
    localparam int SHW  = $clog2(XLEN);
    localparam int LAST = STAGES - 1;
    localparam int MSB  = XLEN - 1;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b1000,
        OP_SLL  = 4'b0001,
        OP_SLT  = 4'b0010,
        OP_SLTU = 4'b0011,
        OP_XOR  = 4'b0100,
        OP_SRL  = 4'b0101,
        OP_SRA  = 4'b1101,
        OP_OR   = 4'b0110,
        OP_AND  = 4'b0111
    } alu_op_e;

    logic [XLEN-1:0]  sum;
    logic [XLEN-1:0]  diff;
    logic [SHW-1:0]   shamt;
    logic [XLEN-1:0]  calc_res;
    logic             calc_ovf;

    logic [STAGES-1:0] stg_valid;
    logic [STAGES-1:0] load;
    logic [XLEN-1:0]   stg_res  [STAGES];
    logic              stg_zero [STAGES];
    logic              stg_ovf  [STAGES];
    logic [TAG_W-1:0]  stg_tag  [STAGES];

    assign sum   = bus.in_a + bus.in_b;
    assign diff  = bus.in_a - bus.in_b;
    assign shamt = bus.in_b[SHW-1:0];

    // Unknown opcodes fall through to zero result with no overflow.
    always_comb begin
        calc_res = '0;
        calc_ovf = 1'b0;
        case (bus.alu_op)
            OP_ADD: begin
                calc_res = sum;
                calc_ovf = (bus.in_a[MSB] == bus.in_b[MSB]) && (sum[MSB] != bus.in_a[MSB]);
            end
            OP_SUB: begin
                calc_res = diff;
                calc_ovf = (bus.in_a[MSB] != bus.in_b[MSB]) && (diff[MSB] != bus.in_a[MSB]);
            end
            OP_SLL:  calc_res = bus.in_a << shamt;
            OP_SLT:  calc_res = {{(XLEN-1){1'b0}}, ($signed(bus.in_a) < $signed(bus.in_b))};
            OP_SLTU: calc_res = {{(XLEN-1){1'b0}}, (bus.in_a < bus.in_b)};
            OP_XOR:  calc_res = bus.in_a ^ bus.in_b;
            OP_SRL:  calc_res = bus.in_a >> shamt;
            OP_SRA:  calc_res = $unsigned($signed(bus.in_a) >>> shamt);
            OP_OR:   calc_res = bus.in_a | bus.in_b;
            OP_AND:  calc_res = bus.in_a & bus.in_b;
            default: begin
                calc_res = '0;
                calc_ovf = 1'b0;
            end
        endcase
    end

    // A stage may load when it is empty or its successor is loading this cycle;
    // the chain starts from out_ready so backpressure ripples back to in_ready.
    always_comb begin
        logic take;
        take = bus.out_ready;
        load = '0;
        for (int k = LAST; k >= 0; k--) begin
            load[k] = !stg_valid[k] || take;
            take    = load[k];
        end
    end

    // Payload only moves when a valid op moves into a stage, so idle stages keep their contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_valid <= '0;
            for (int k = 0; k < STAGES; k++) begin
                stg_res[k]  <= '0;
                stg_zero[k] <= 1'b0;
                stg_ovf[k]  <= 1'b0;
                stg_tag[k]  <= '0;
            end
        end else begin
            if (load[0]) begin
                stg_valid[0] <= bus.in_valid;
            end
            if (load[0] && bus.in_valid) begin
                stg_res[0]  <= calc_res;
                stg_zero[0] <= (calc_res == '0);
                stg_ovf[0]  <= calc_ovf;
                stg_tag[0]  <= bus.in_tag;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (load[k]) begin
                    stg_valid[k] <= stg_valid[k-1];
                end
                if (load[k] && stg_valid[k-1]) begin
                    stg_res[k]  <= stg_res[k-1];
                    stg_zero[k] <= stg_zero[k-1];
                    stg_ovf[k]  <= stg_ovf[k-1];
                    stg_tag[k]  <= stg_tag[k-1];
                end
            end
        end
    end

    assign bus.in_ready  = load[0];
    assign bus.out_valid = stg_valid[LAST];
    assign bus.result    = stg_res[LAST];
    assign bus.zero      = stg_zero[LAST];
    assign bus.overflow  = stg_ovf[LAST];
    assign bus.out_tag   = stg_tag[LAST];
endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed corner cases plus randomized traffic,
// scored against a plain-arithmetic reference model and an in-order expectation queue.
module tb_alu_pipe;
    localparam int XLEN   = 32;
    localparam int STAGES = 2;
    localparam int TAG_W  = 5;
    localparam longint MAX_S = 64'sd2147483647;
    localparam longint MIN_S = -64'sd2147483648;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        ovf;
        logic [4:0]  tag;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_compared   = 0;
    int   n_mismatched = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    alu_pipe_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    alu_pipe #(.XLEN(XLEN), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] tag);
        exp_t   e;
        longint sa, sb, wide;
        int     sh;
        sa    = $signed(a);
        sb    = $signed(b);
        sh    = int'(b % 32);
        e.res = '0;
        e.ovf = 1'b0;
        e.tag = tag;
        case (op)
            4'b0000: begin wide = sa + sb; e.res = a + b; e.ovf = (wide > MAX_S) || (wide < MIN_S); end
            4'b1000: begin wide = sa - sb; e.res = a - b; e.ovf = (wide > MAX_S) || (wide < MIN_S); end
            4'b0001: e.res = a << sh;
            4'b0010: e.res = (sa < sb) ? 32'd1 : 32'd0;
            4'b0011: e.res = (a < b) ? 32'd1 : 32'd0;
            4'b0100: e.res = a ^ b;
            4'b0101: e.res = a >> sh;
            4'b1101: begin wide = sa >>> sh; e.res = wide[31:0]; end
            4'b0110: e.res = a | b;
            4'b0111: e.res = a & b;
            default: e.res = '0;
        endcase
        e.zero = (e.res == 32'd0);
        return e;
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic drive_random();
        bus.in_valid = 1'b1;
        bus.alu_op   = 4'($urandom_range(0, 15));
        bus.in_a     = rand_word();
        bus.in_b     = ($urandom_range(0, 3) == 0) ? bus.in_a : rand_word();
        bus.in_tag   = 5'($urandom);
    endtask

    // Scoreboard: every accepted op is modelled on entry and must leave in order.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                n_compared++;
                if (exp_q.size() == 0) begin
                    n_mismatched++;
                    $display("[TB] FAIL scoreboard_extra got res=%h tag=%0d want no output", bus.result, bus.out_tag);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if ({bus.result, bus.zero, bus.overflow, bus.out_tag} !== {e.res, e.zero, e.ovf, e.tag}) begin
                        n_mismatched++;
                        $display("[TB] FAIL scoreboard got res=%h z=%b o=%b tag=%0d want res=%h z=%b o=%b tag=%0d",
                                 bus.result, bus.zero, bus.overflow, bus.out_tag, e.res, e.zero, e.ovf, e.tag);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(model(bus.alu_op, bus.in_a, bus.in_b, bus.in_tag));
        end
    end

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.alu_op    = '0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_tag    = '0;
        rst_n         = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        n_compared++;
        if (bus.out_valid !== 1'b0) begin
            n_mismatched++; $display("[TB] FAIL reset_out_valid got %b want 0", bus.out_valid);
        end
        n_compared++;
        if (bus.result !== 32'd0) begin
            n_mismatched++; $display("[TB] FAIL reset_result got %h want 0", bus.result);
        end
        n_compared++;
        if ({bus.zero, bus.overflow} !== 2'b00) begin
            n_mismatched++; $display("[TB] FAIL reset_flags got %b want 00", {bus.zero, bus.overflow});
        end
        n_compared++;
        if (bus.out_tag !== 5'd0) begin
            n_mismatched++; $display("[TB] FAIL reset_tag got %0d want 0", bus.out_tag);
        end
        n_compared++;
        if (bus.in_ready !== 1'b1) begin
            n_mismatched++; $display("[TB] FAIL reset_in_ready got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_add_overflow();
        logic [4:0] tag;
        tag = 5'($urandom);
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.alu_op = 4'b0000;
        bus.in_a = 32'h7FFF_FFFF; bus.in_b = 32'h0000_0001; bus.in_tag = tag;
        @(negedge clk);
        n_compared++;
        if (bus.in_ready !== 1'b1) begin
            n_mismatched++; $display("[TB] FAIL add_in_ready got %b want 1", bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        for (int i = 1; i < STAGES; i++) begin
            @(negedge clk);
            n_compared++;
            if (bus.out_valid !== 1'b0) begin
                n_mismatched++; $display("[TB] FAIL add_early_valid got %b want 0 at cycle %0d", bus.out_valid, i);
            end
            @(posedge clk);
        end
        @(negedge clk);
        n_compared++;
        if ({bus.out_valid, bus.result, bus.zero, bus.overflow, bus.out_tag} !==
            {1'b1, 32'h8000_0000, 1'b0, 1'b1, tag}) begin
            n_mismatched++;
            $display("[TB] FAIL add_overflow got v=%b res=%h z=%b o=%b tag=%0d want v=1 res=80000000 z=0 o=1 tag=%0d",
                     bus.out_valid, bus.result, bus.zero, bus.overflow, bus.out_tag, tag);
        end
    endtask

    task automatic test_directed();
        logic [3:0]  ops  [8] = '{4'b1000, 4'b1101, 4'b0010, 4'b0011, 4'b1111, 4'b1000, 4'b0000, 4'b0001};
        logic [31:0] as   [8] = '{32'h5, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678,
                                  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0001};
        logic [31:0] bs   [8] = '{32'h5, 32'h21, 32'h1, 32'h1, 32'h9ABC_DEF0, 32'h1, 32'h1, 32'h21};
        logic [31:0] ress [8] = '{32'h0, 32'hC000_0000, 32'h1, 32'h0, 32'h0, 32'h7FFF_FFFF, 32'h0, 32'h2};
        logic [1:0]  flags[8] = '{2'b10, 2'b00, 2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b00};
        for (int i = 0; i < 8; i++) begin
            int w;
            @(posedge clk); #1;
            bus.in_valid = 1'b1; bus.alu_op = ops[i];
            bus.in_a = as[i]; bus.in_b = bs[i]; bus.in_tag = 5'(i);
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            w = 0;
            while (bus.out_valid !== 1'b1 && w < 20) begin
                @(negedge clk);
                w++;
            end
            n_compared++;
            if ({bus.out_valid, bus.result, bus.zero, bus.overflow} !== {1'b1, ress[i], flags[i]}) begin
                n_mismatched++;
                $display("[TB] FAIL directed_%0d got v=%b res=%h zo=%b%b want v=1 res=%h zo=%b",
                         i, bus.out_valid, bus.result, bus.zero, bus.overflow, ress[i], flags[i]);
            end
        end
        @(posedge clk);
    endtask

    task automatic test_back_to_back();
        int first = -1;
        int last  = -1;
        int cnt   = 0;
        for (int c = 0; c < 10 + STAGES + 4; c++) begin
            @(posedge clk); #1;
            if (c < 10) drive_random();
            else bus.in_valid = 1'b0;
            @(negedge clk);
            if (c < 10) begin
                n_compared++;
                if (bus.in_ready !== 1'b1) begin
                    n_mismatched++; $display("[TB] FAIL b2b_in_ready got %b want 1 at cycle %0d", bus.in_ready, c);
                end
            end
            if (bus.out_valid === 1'b1) begin
                if (first < 0) first = c;
                last = c;
                cnt++;
            end
        end
        n_compared++;
        if ({cnt, first, last} !== {32'd10, 32'(STAGES), 32'(STAGES + 9)}) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_window got count=%0d first=%0d last=%0d want count=10 first=%0d last=%0d",
                     cnt, first, last, STAGES, STAGES + 9);
        end
    endtask

    task automatic test_backpressure();
        int          accepted = 0;
        bit          pending  = 1'b0;
        bit          captured = 1'b0;
        logic [38:0] held;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
            if (!pending) begin
                drive_random();
                pending = 1'b1;
            end
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                accepted++;
                pending = 1'b0;
            end
            if (bus.out_valid === 1'b1) begin
                if (!captured) begin
                    held     = {bus.result, bus.zero, bus.overflow, bus.out_tag};
                    captured = 1'b1;
                end else begin
                    n_compared++;
                    if ({bus.result, bus.zero, bus.overflow, bus.out_tag} !== held) begin
                        n_mismatched++;
                        $display("[TB] FAIL bp_stable got %h want %h at cycle %0d",
                                 {bus.result, bus.zero, bus.overflow, bus.out_tag}, held, c);
                    end
                end
            end
        end
        n_compared++;
        if ({accepted, bus.in_ready, bus.out_valid} !== {32'(STAGES), 1'b0, 1'b1}) begin
            n_mismatched++;
            $display("[TB] FAIL bp_fill got accepted=%0d in_ready=%b out_valid=%b want accepted=%0d in_ready=0 out_valid=1",
                     accepted, bus.in_ready, bus.out_valid, STAGES);
        end
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (STAGES + 3) @(posedge clk);
        @(negedge clk);
        n_compared++;
        if (exp_q.size() != 0) begin
            n_mismatched++; $display("[TB] FAIL bp_drain got %0d outstanding want 0", exp_q.size());
        end
    endtask

    task automatic test_random();
        bit fired = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            if (fired || !bus.in_valid) begin
                drive_random();
                bus.in_valid = ($urandom_range(0, 9) < 7);
            end
            bus.out_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            fired = bus.in_valid && bus.in_ready;
        end
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (STAGES + 3) @(posedge clk);
        @(negedge clk);
        n_compared++;
        if (exp_q.size() != 0) begin
            n_mismatched++; $display("[TB] FAIL random_drain got %0d outstanding want 0", exp_q.size());
        end
    endtask

    task automatic test_reset_midflight();
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            drive_random();
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_compared++;
        if (bus.out_valid !== 1'b1) begin
            n_mismatched++; $display("[TB] FAIL midrst_full got out_valid=%b want 1", bus.out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        n_compared++;
        if ({bus.out_valid, bus.result, bus.zero, bus.overflow, bus.out_tag} !== 40'd0) begin
            n_mismatched++;
            $display("[TB] FAIL midrst_async got v=%b res=%h z=%b o=%b tag=%0d want all 0",
                     bus.out_valid, bus.result, bus.zero, bus.overflow, bus.out_tag);
        end
        @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < STAGES + 3; i++) begin
            @(negedge clk);
            n_compared++;
            if (bus.out_valid !== 1'b0) begin
                n_mismatched++; $display("[TB] FAIL midrst_stale got out_valid=%b want 0 at cycle %0d", bus.out_valid, i);
            end
        end
        @(posedge clk); #1;
        drive_random();
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (STAGES + 2) @(posedge clk);
        @(negedge clk);
        n_compared++;
        if (exp_q.size() != 0) begin
            n_mismatched++; $display("[TB] FAIL midrst_fresh got %0d outstanding want 0", exp_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_add_overflow();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
